// File: rtl/bus_sequencer.sv
// Multi-cycle control FSM that sequences bus selects, register writes and ALU control.
// Define BUS_SEQ_MVNZ_EN to decode opcode 100 as mvnz; otherwise it decodes as a NOP.
module bus_sequencer #(
    parameter int NREGS = 8,
    parameter int IR_W  = 9
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             run,
    input  logic [IR_W-1:0]  instr,
    input  logic             g_nz,
    output logic             imediate_select,
    output logic             r_select,
    output logic [NREGS-1:0] reg_select,
    output logic [NREGS-1:0] reg_in,
    output logic             a_in,
    output logic             g_in,
    output logic             addsub,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
`ifdef BUS_SEQ_MVNZ_EN
    localparam logic [2:0] OP_MVNZ = 3'b100;
`endif

    logic [1:0]       state;
    logic [IR_W-1:0]  ir;
    logic [2:0]       opcode;
    logic [2:0]       rx;
    logic [2:0]       ry;
    logic [NREGS-1:0] x_hot;
    logic [NREGS-1:0] y_hot;
    logic             is_arith;

    assign opcode   = ir[8:6];
    assign rx       = ir[5:3];
    assign ry       = ir[2:0];
    assign x_hot    = NREGS'(1) << rx;
    assign y_hot    = NREGS'(1) << ry;
    assign is_arith = (opcode == OP_ADD) || (opcode == OP_SUB);

`ifndef BUS_SEQ_MVNZ_EN
    logic unused_g_nz;
    assign unused_g_nz = g_nz;
`endif

    // run is only honoured in T0, so a held-high run starts the next instruction after done
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= T0;
            ir    <= '0;
        end else begin
            case (state)
                T0: begin
                    if (run) begin
                        ir    <= instr;
                        state <= T1;
                    end
                end
                T1:      state <= is_arith ? T2 : T0;
                T2:      state <= T3;
                T3:      state <= T0;
                default: state <= T0;
            endcase
        end
    end

    // Each state drives at most one bus source and at most one register write
    always_comb begin
        imediate_select = 1'b0;
        r_select        = 1'b0;
        reg_select      = '0;
        reg_in          = '0;
        a_in            = 1'b0;
        g_in            = 1'b0;
        addsub          = 1'b0;
        done            = 1'b0;
        busy            = (state != T0);
        case (state)
            T1: begin
                case (opcode)
                    OP_MV: begin
                        reg_select = y_hot;
                        reg_in     = x_hot;
                        done       = 1'b1;
                    end
                    OP_MVI: begin
                        imediate_select = 1'b1;
                        reg_in          = x_hot;
                        done            = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        reg_select = x_hot;
                        a_in       = 1'b1;
                    end
`ifdef BUS_SEQ_MVNZ_EN
                    OP_MVNZ: begin
                        if (g_nz) begin
                            reg_select = y_hot;
                            reg_in     = x_hot;
                        end
                        done = 1'b1;
                    end
`endif
                    default: done = 1'b1;
                endcase
            end
            T2: begin
                reg_select = y_hot;
                g_in       = 1'b1;
                addsub     = (opcode == OP_SUB);
            end
            T3: begin
                r_select = 1'b1;
                reg_in   = x_hot;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer: a queue-of-beats instruction model checked every cycle,
// plus hand-computed literal expectations at key cycles.
module tb_bus_sequencer;

    logic       clock = 1'b0;
    logic       resetn;
    logic       run;
    logic [8:0] instr;
    logic       g_nz;
    logic       imediate_select;
    logic       r_select;
    logic [7:0] reg_select;
    logic [7:0] reg_in;
    logic       a_in;
    logic       g_in;
    logic       addsub;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    bus_sequencer #(.NREGS(8), .IR_W(9)) dut (
        .clock(clock), .resetn(resetn), .run(run), .instr(instr), .g_nz(g_nz),
        .imediate_select(imediate_select), .r_select(r_select),
        .reg_select(reg_select), .reg_in(reg_in), .a_in(a_in), .g_in(g_in),
        .addsub(addsub), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // {imm, rsel, regsel[7:0], regin[7:0], a, g, addsub, busy, done}
    logic [22:0] out_vec;
    assign out_vec = {imediate_select, r_select, reg_select, reg_in, a_in, g_in, addsub, busy, done};

    // Each entry holds the expected cycle for g_nz=1 (upper half) and g_nz=0 (lower half)
    logic [45:0] beats[$];

    function automatic logic [22:0] pk(input logic imm, input logic rs, input logic [7:0] sel,
                                       input logic [7:0] win, input logic a, input logic g,
                                       input logic as, input logic dn);
        return {imm, rs, sel, win, a, g, as, 1'b1, dn};
    endfunction

    task automatic push_instr(input logic [8:0] ins);
        logic [7:0] bx;
        logic [7:0] by;
        bx = 8'd1 << ins[5:3];
        by = 8'd1 << ins[2:0];
        case (ins[8:6])
            3'b000: beats.push_back({2{pk(0, 0, by, bx, 0, 0, 0, 1)}});
            3'b001: beats.push_back({2{pk(1, 0, 8'h00, bx, 0, 0, 0, 1)}});
            3'b010, 3'b011: begin
                beats.push_back({2{pk(0, 0, bx, 8'h00, 1, 0, 0, 0)}});
                beats.push_back({2{pk(0, 0, by, 8'h00, 0, 1, ins[6], 0)}});
                beats.push_back({2{pk(0, 1, 8'h00, bx, 0, 0, 0, 1)}});
            end
`ifdef BUS_SEQ_MVNZ_EN
            3'b100: beats.push_back({pk(0, 0, by, bx, 0, 0, 0, 1), pk(0, 0, 8'h00, 8'h00, 0, 0, 0, 1)});
`endif
            default: beats.push_back({2{pk(0, 0, 8'h00, 8'h00, 0, 0, 0, 1)}});
        endcase
    endtask

    // An empty queue means the sequencer is idle and may accept run
    always @(posedge clock) begin
        if (!resetn) beats.delete();
        else if (beats.size() > 0) void'(beats.pop_front());
        else if (run) push_instr(instr);
    end

    always @(negedge clock) begin
        logic [22:0] exp_vec;
        #2;
        if (armed) begin
            exp_vec = '0;
            if (beats.size() > 0) exp_vec = g_nz ? beats[0][45:23] : beats[0][22:0];
            checks++;
            if (out_vec !== exp_vec) begin
                errors++;
                $display("FAIL model t=%0t got %b want %b", $time, out_vec, exp_vec);
            end
            checks++;
            if ($countones({imediate_select, r_select, reg_select}) > 1 || $countones(reg_in) > 1 ||
                $isunknown(out_vec)) begin
                errors++;
                $display("FAIL onehot t=%0t sel=%b reg_in=%b", $time,
                         {imediate_select, r_select, reg_select}, reg_in);
            end
        end
    end

    task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clock);
    endtask

    logic [8:0] table_ins[7];

    initial begin
        table_ins = '{9'b000_110_001, 9'b010_010_010, 9'b011_111_011, 9'b111_000_000,
                      9'b101_001_010, 9'b110_100_100, 9'b001_000_000};
        resetn = 1'b0;
        run    = 1'b1;
        instr  = 9'b001_011_000;
        g_nz   = 1'b0;
        nxt();
        armed = 1'b1;
        nxt();
        pin("reset_outputs", 32'(out_vec), 32'h0);
        pin("reset_busy", 32'(busy), 32'h0);

        // mvi r3
        resetn = 1'b1;
        nxt();
        pin("mvi_imm", 32'(imediate_select), 32'h1);
        pin("mvi_reg_in", 32'(reg_in), 32'h08);
        pin("mvi_done", 32'(done), 32'h1);
        run = 1'b0;
        nxt();
        pin("mvi_after", 32'(out_vec), 32'h0);

        // add r1,r5
        run = 1'b1;
        instr = 9'b010_001_101;
        nxt();
        run = 1'b0;
        pin("add_t1", 32'({reg_select, a_in, done}), 32'({8'h02, 1'b1, 1'b0}));
        nxt();
        pin("add_t2", 32'({reg_select, g_in, addsub}), 32'({8'h20, 1'b1, 1'b0}));
        nxt();
        pin("add_t3", 32'({r_select, reg_in, done}), 32'({1'b1, 8'h02, 1'b1}));
        nxt();
        pin("add_idle", 32'(out_vec), 32'h0);

        // sub r0,r0 with run held high; mvi r3 follows
        run = 1'b1;
        instr = 9'b011_000_000;
        nxt();
        pin("sub_t1", 32'(reg_select), 32'h01);
        nxt();
        pin("sub_t2_addsub", 32'(addsub), 32'h1);
        nxt();
        pin("sub_t3_done", 32'(done), 32'h1);
        instr = 9'b001_011_000;
        nxt();
        pin("held_t0", 32'(busy), 32'h0);
        nxt();
        pin("held_next_imm", 32'(imediate_select), 32'h1);
        run = 1'b0;
        nxt();

        // reset during T2 of add
        run = 1'b1;
        instr = 9'b010_001_101;
        nxt();
        run = 1'b0;
        nxt();
        pin("rst_mid_t2_g_in", 32'(g_in), 32'h1);
        resetn = 1'b0;
        nxt();
        pin("rst_mid_after", 32'({reg_in, done, busy}), 32'h0);
        resetn = 1'b1;
        nxt();

        // mvnz r2,r4 with g_nz high then low
        g_nz = 1'b1;
        run = 1'b1;
        instr = 9'b100_010_100;
        nxt();
        run = 1'b0;
`ifdef BUS_SEQ_MVNZ_EN
        pin("mvnz_nz1", 32'({reg_select, reg_in, done}), 32'({8'h10, 8'h04, 1'b1}));
`else
        pin("mvnz_nz1", 32'({reg_select, reg_in, done}), 32'({8'h00, 8'h00, 1'b1}));
`endif
        nxt();
        g_nz = 1'b0;
        run = 1'b1;
        nxt();
        run = 1'b0;
        pin("mvnz_nz0", 32'({reg_select, reg_in, done}), 32'({8'h00, 8'h00, 1'b1}));
        nxt();

        // remaining opcodes, X==Y and unused encodings, checked by the model
        foreach (table_ins[i]) begin
            run = 1'b1;
            instr = table_ins[i];
            g_nz = i[0];
            nxt();
            run = 1'b0;
            repeat (4) nxt();
        end
        pin("end_idle", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
